// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller beside the ID stage: EX/MEM/WB destination scoreboard,
// load-use stall FSM, jump flush and memory freeze. Perf counters built with HAZARD_PERF_CNT_EN.
module hazard_forward_ctrl #(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_ra,
  input  logic [4:0]       id_rb,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_le,
  input  logic             id_load,
  input  logic             ex_jump,
  input  logic             mem_busy,
  output logic [1:0]       fw_a_sel,
  output logic [1:0]       fw_b_sel,
  output logic             nop_sel,
  output logic             jump_sel,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_clr,
  output logic             pipe_le,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_LDSTALL, ST_FREEZE} state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       rf_le;
    logic       load;
  } sb_entry_t;

  state_t     r_state;
  state_t     r_saved;
  state_t     w_eff_state;
  state_t     w_next_state;
  sb_entry_t  r_ex;
  sb_entry_t  r_mem;
  sb_entry_t  r_wb;
  logic       w_load_use;
  logic [1:0] w_fw_a;
  logic [1:0] w_fw_b;
  logic       w_nop;
  logic       w_jump;
  logic       w_pc_le;
  logic       w_ifid_le;
  logic       w_ifid_clr;
  logic       w_pipe_le;

  // Youngest in-flight writer wins; GR0 is hard-wired zero so it never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic      use_src,
    input logic [4:0] src,
    input sb_entry_t ex,
    input sb_entry_t mem,
    input sb_entry_t wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && (src != 5'd0)) begin
      if (ex.rf_le && (ex.rd == src))        sel = 2'b01;
      else if (mem.rf_le && (mem.rd == src)) sel = 2'b10;
      else if (wb.rf_le && (wb.rd == src))   sel = 2'b11;
    end
    return sel;
  endfunction

  assign w_fw_a = fwd_sel(id_use_ra, id_ra, r_ex, r_mem, r_wb);
  assign w_fw_b = fwd_sel(id_use_rb, id_rb, r_ex, r_mem, r_wb);

  assign w_load_use = r_ex.load && r_ex.rf_le && (r_ex.rd != 5'd0) &&
                      ((id_use_ra && (id_ra == r_ex.rd)) ||
                       (id_use_rb && (id_rb == r_ex.rd)));

  // While frozen, decisions are made as if still in the pre-freeze state.
  assign w_eff_state = (r_state == ST_FREEZE) ? r_saved : r_state;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_nop        = 1'b0;
    w_jump       = 1'b0;
    w_pc_le      = 1'b1;
    w_ifid_le    = 1'b1;
    w_ifid_clr   = 1'b0;
    w_pipe_le    = 1'b1;
    w_next_state = ST_RUN;
    if (reset) begin
      w_next_state = ST_RUN;
    end else if (mem_busy) begin
      w_pc_le      = 1'b0;
      w_ifid_le    = 1'b0;
      w_pipe_le    = 1'b0;
      w_next_state = ST_FREEZE;
    end else if (ex_jump) begin
      w_jump       = 1'b1;
      w_ifid_clr   = 1'b1;
      w_nop        = (DELAY_SLOT == 0) ? 1'b1 : 1'b0;
      w_next_state = ST_RUN;
    end else if ((w_eff_state == ST_RUN) && w_load_use) begin
      w_nop        = 1'b1;
      w_pc_le      = 1'b0;
      w_ifid_le    = 1'b0;
      w_next_state = ST_LDSTALL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_state <= ST_RUN;
      r_saved <= ST_RUN;
    end else begin
      r_state <= w_next_state;
      if (mem_busy && (r_state != ST_FREEZE)) r_saved <= r_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (w_pipe_le) begin
      r_ex.rd    <= id_rd;
      r_ex.rf_le <= id_rf_le && !w_nop;
      r_ex.load  <= id_load && !w_nop;
      r_mem      <= r_ex;
      r_wb       <= r_mem;
    end
  end

  assign fw_a_sel = reset ? 2'b00 : w_fw_a;
  assign fw_b_sel = reset ? 2'b00 : w_fw_b;
  assign nop_sel  = w_nop;
  assign jump_sel = w_jump;
  assign pc_le    = w_pc_le;
  assign ifid_le  = w_ifid_le;
  assign ifid_clr = w_ifid_clr;
  assign pipe_le  = w_pipe_le;

`ifdef HAZARD_PERF_CNT_EN
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_stall_evt = (w_next_state == ST_LDSTALL);
  assign w_flush_evt = ex_jump && !mem_busy && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
